gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for a single 2-input logic gate such as the xor/and gate cells. On a start request it drives the gate inputs through all four input vectors and samples the gate output after a programmable settle time. It compares each sample against an expected truth table and reports pass/fail with a per-vector failure mask. It sits between a test host (or bench) and one gate instance, and owns the gate's `a`/`b` inputs while a test runs.

## Interface
- `EXPECT`, default 4'b0110 (XOR): expected truth table; bit `i` is the expected `y` for `{a,b} = i`.
- `SETTLE`, default 1: extra wait cycles per vector before sampling; legal range is 0..15.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: test request; sampled only in IDLE.
- `gate_a  out  1`: gate input a, equal to `vec_idx[1]` during RUN.
- `gate_b  out  1`: gate input b, equal to `vec_idx[0]` during RUN.
- `gate_y  in  1`: gate output under test.
- `busy  out  1`: high while in RUN.
- `done  out  1`: one-cycle pulse in FINISH.
- `pass  out  1`: result of the last test; valid from `done` until the next accepted start.
- `fail_mask  out  4`: bit `i` is set if vector `i` mismatched.
- `vec_idx  out  2`: current or last-tested vector index.

## Operation
- FSM states: IDLE, RUN, FINISH.
- Reset: state IDLE; all outputs 0 (`gate_a`, `gate_b`, `busy`, `done`, `pass`, `fail_mask`, `vec_idx`).
- IDLE with `start`=1 at an edge:
  - state becomes RUN;
  - `vec_idx` and the settle counter `cnt` become 0;
  - `fail_mask` and `pass` clear;
  - `busy` becomes 1.
- RUN, at each edge:
  - if `cnt != SETTLE`: `cnt` increments.
  - if `cnt == SETTLE`: compare `gate_y` against `EXPECT[vec_idx]` and OR any mismatch into `fail_mask[vec_idx]`. Then, if `vec_idx == 3`, go to FINISH; otherwise increment `vec_idx` and clear `cnt`.
- FINISH: `done`=1 and `busy`=0; `pass` = (`fail_mask` == 0), registered on entry. The next edge returns to IDLE unconditionally.
- `gate_a`/`gate_b` are 0 outside RUN.
- `vec_idx` holds its last value after FINISH until the next accepted start.
- `start` during RUN or FINISH is ignored, not queued.
- `start` held high: a new run begins on the first IDLE edge after FINISH.
- `rst` during RUN or FINISH aborts the test: no `done` pulse, and all outputs return to reset values on that edge.
- `cnt` is 4 bits wide; the `cnt == SETTLE` compare is exact, so there is no wrap.

## Timing
- Each vector occupies SETTLE+1 cycles, and `gate_y` is sampled on the last of them. The gate therefore has at least SETTLE+1 cycles to settle before it is sampled.
- `done` goes high after the edge that lies 4·(SETTLE+1) edges after the edge that accepted `start`, and stays high for exactly one cycle.
- Minimum start-to-start spacing is 4·(SETTLE+1)+2 edges.
- All outputs are registered; none are combinational from inputs.

## Configuration
- Macro `GATE_BIST_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch goes directly from RUN to FINISH. `fail_mask` has exactly one bit set, `vec_idx` holds the failing index, and `done` arrives early, at (vec_idx+1)·(SETTLE+1) edges after start.
  - Undefined: all four vectors are always tested, and the latency is fixed.

## Structure
- Shared package `gate_bist_pkg` holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, FINISH=2'd2;
  - `NUM_VEC`=4;
  - the truth-table constants `TT_XOR`=4'b0110, `TT_AND`=4'b1000, `TT_OR`=4'b1110.
- One natural sub-module, `bist_settle_cnt`: the settle counter, with load/clear and a terminal flag at `cnt == SETTLE`.
- The FSM, compare logic and result registers stay in the top module.

## Test plan
- XOR gate attached, `EXPECT`=`TT_XOR`, `SETTLE`=1, one-cycle start.
  - Required: `{gate_a,gate_b}` = 00, 01, 10, 11, each held 2 cycles.
  - Required: `done` after 8 edges, `pass`=1, `fail_mask`=4'b0000.
- AND gate attached, `EXPECT`=`TT_XOR`, `SETTLE`=1.
  - Required: `pass`=0, `fail_mask`=4'b1110, `vec_idx`=3.
- `SETTLE`=0 with `start` held high.
  - Required: `done` after 4 edges.
  - Required: the second run accepts `start` 2 edges after `done` rises, and `pass`/`fail_mask` clear on acceptance.
- `rst` asserted on an edge during RUN at `vec_idx`=2.
  - Required: all outputs 0 after that edge and no `done`.
  - Required: the following start runs the full sequence with correct results.
- `start` pulsed again at `vec_idx`=1 during RUN.
  - Required: ignored; the sequence and `done` timing are unchanged.
- `GATE_BIST_STOP_ON_FAIL_EN` defined, AND gate attached, `EXPECT`=`TT_XOR`, `SETTLE`=1.
  - Required: `done` after 4 edges, `fail_mask`=4'b0010, `vec_idx`=1, `pass`=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned NUM_VEC = 4;

  localparam logic [3:0] TT_XOR = 4'b0110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;

endpackage

// File: rtl/bist_settle_cnt.sv
// Per-vector settle counter; term flags the sample cycle (cnt == SETTLE).
module bist_settle_cnt
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       term
);

  assign term = (cnt == 4'(SETTLE));

  // Holds at SETTLE rather than wrapping; the FSM clears it per vector.
  always_ff @(posedge clk) begin
    if (rst || clr)       cnt <= '0;
    else if (en && !term) cnt <= cnt + 4'd1;
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for one 2-input gate: walks {a,b} through 00..11, samples y.
// Optional GATE_BIST_STOP_ON_FAIL_EN: end the test at the first mismatch.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter logic [3:0]  EXPECT = TT_XOR,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t     state, state_n;
  logic [1:0] vec_n;
  logic [3:0] mask_n, miss_oh;
  logic       pass_n, miss, cnt_clr, term;
  logic [3:0] cnt;

  bist_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (state == RUN),
    .cnt  (cnt),
    .term (term)
  );

  // Outputs decode registered state only, so nothing is combinational from inputs.
  assign busy   = (state == RUN);
  assign done   = (state == FINISH);
  assign gate_a = busy & vec_idx[1];
  assign gate_b = busy & vec_idx[0];

  assign miss = (gate_y != EXPECT[vec_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_idx   <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      vec_idx   <= vec_n;
      fail_mask <= mask_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    vec_n   = vec_idx;
    mask_n  = fail_mask;
    pass_n  = pass;
    cnt_clr = 1'b0;
    miss_oh = '0;
    miss_oh[vec_idx] = miss;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          vec_n   = '0;
          mask_n  = '0;
          pass_n  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (term) begin
          mask_n = fail_mask | miss_oh;
          if ((STOP_ON_FAIL && miss) || (vec_idx == 2'(NUM_VEC - 1))) begin
            state_n = FINISH;
            pass_n  = (mask_n == '0);
          end else begin
            vec_n   = vec_idx + 2'd1;
            cnt_clr = 1'b1;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench: one DUT with SETTLE=1, one with SETTLE=0, each driving a modelled gate.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic start1 = 1'b0, start0 = 1'b0;
  logic and1 = 1'b0, and0 = 1'b0;
  logic a1, b1, y1, busy1, done1, pass1;
  logic a0, b0, y0, busy0, done0, pass0;
  logic [3:0] mask1, mask0;
  logic [1:0] idx1, idx0;
  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  // Gate under test: XOR by default, AND when the andX select is high.
  assign y1 = and1 ? (a1 & b1) : (a1 ^ b1);
  assign y0 = and0 ? (a0 & b0) : (a0 ^ b0);

  gate_bist_ctrl #(.EXPECT(TT_XOR), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .gate_a(a1), .gate_b(b1), .gate_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1), .vec_idx(idx1)
  );

  gate_bist_ctrl #(.EXPECT(TT_XOR), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start0), .gate_a(a0), .gate_b(b0), .gate_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0), .vec_idx(idx0)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full SETTLE=1 run on u_s1; optional extra start pulse after edge pulse_at.
  task automatic run_s1(input string tag, input int exp_edges, input logic [3:0] exp_mask,
                        input logic [1:0] exp_idx, input int pulse_at);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk({tag, "_acc_busy"}, 8'(busy1), 8'd1);
    chk({tag, "_acc_mask"}, 8'(mask1), 8'd0);
    for (int k = 0; k < exp_edges; k++) begin
      chk($sformatf("%s_ab%0d", tag, k), 8'({a1, b1}), 8'(k >> 1));
      chk($sformatf("%s_nodone%0d", tag, k), 8'(done1), 8'd0);
      if (k == pulse_at) start1 = 1'b1;
      step();
      start1 = 1'b0;
    end
    chk({tag, "_done"}, 8'(done1), 8'd1);
    chk({tag, "_busy_fin"}, 8'(busy1), 8'd0);
    chk({tag, "_pass"}, 8'(pass1), 8'(exp_mask == 4'd0));
    chk({tag, "_mask"}, 8'(mask1), 8'(exp_mask));
    chk({tag, "_idx"}, 8'(idx1), 8'(exp_idx));
    step();
    chk({tag, "_done_1cyc"}, 8'(done1), 8'd0);
    chk({tag, "_idx_hold"}, 8'(idx1), 8'(exp_idx));
    chk({tag, "_ab_idle"}, 8'({a1, b1}), 8'd0);
    chk({tag, "_pass_hold"}, 8'(pass1), 8'(exp_mask == 4'd0));
  endtask

  initial begin
    step(); step();
    chk("rst_s1", 8'({a1, b1, busy1, done1, pass1, mask1 != 4'd0, idx1 != 2'd0}), 8'd0);
    chk("rst_s0", 8'({a0, b0, busy0, done0, pass0, mask0 != 4'd0, idx0 != 2'd0}), 8'd0);
    rst = 1'b0;
    step();

    // XOR gate, expected XOR: all vectors pass, done 8 edges after accept.
    run_s1("xor", 8, 4'b0000, 2'd3, -1);

    // AND gate against XOR table.
    and1 = 1'b1;
    if (STOP) run_s1("and", 4, 4'b0010, 2'd1, -1);
    else      run_s1("and", 8, 4'b1110, 2'd3, -1);
    and1 = 1'b0;

    // Extra start mid-run (vec_idx=1) must be ignored.
    run_s1("ign", 8, 4'b0000, 2'd3, 2);
    step();
    chk("ign_no_requeue", 8'(busy1), 8'd0);

    // Reset during RUN at vec_idx=2 aborts without done.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("abort_idx2", 8'(idx1), 8'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs", 8'({a1, b1, busy1, done1, pass1, mask1 != 4'd0, idx1 != 2'd0}), 8'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("abort_nodone%0d", k), 8'({done1, busy1}), 8'd0);
      step();
    end
    run_s1("post", 8, 4'b0000, 2'd3, -1);

    // SETTLE=0 with start held: done 4 edges after accept, re-accept 2 edges after done.
    start0 = 1'b1;
    step();
    chk("s0_acc", 8'({busy0, idx0}), 8'b100);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("s0_idx%0d", k), 8'({done0, idx0}), 8'(k));
    end
    step();
    chk("s0_done", 8'({done0, busy0, pass0}), 8'b101);
    chk("s0_mask", 8'(mask0), 8'd0);
    step();
    chk("s0_idle", 8'({done0, busy0, pass0}), 8'b001);
    step();
    chk("s0_reacc", 8'({busy0, pass0, idx0}), 8'b1000);
    chk("s0_reacc_mask", 8'(mask0), 8'd0);
    start0 = 1'b0;
    and0 = 1'b1;
    if (STOP) begin
      step(); step();
      chk("s0_and_done", 8'({done0, pass0, idx0}), 8'b1001);
      chk("s0_and_mask", 8'(mask0), 8'b0010);
    end else begin
      step(); step(); step();
      chk("s0_and_nodone", 8'(done0), 8'd0);
      step();
      chk("s0_and_done", 8'({done0, pass0, idx0}), 8'b1011);
      chk("s0_and_mask", 8'(mask0), 8'b1110);
    end
    step();
    chk("s0_and_end", 8'({done0, busy0}), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
